multicycle_control_unit: RTL and testbench

- Multicycle control FSM sitting directly upstream of the datapath.
- Consumes the fetched instruction word and the ALU zero flag.
- Drives every datapath control input: PC select/load, register-file write and selects, ALU selects and function, memory write enable.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, asserting only the enables each state needs.

---
 rtl/multicycle_control_unit_if.sv | 30 +++
 rtl/multicycle_control_unit.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multicycle control FSM (master) and the datapath (slave).
// Carries the instruction word and zero flag in, and every datapath control out.
interface multicycle_control_unit_if;
   logic [31:0] Instr;
   logic        Zero;
   logic        instr_lden;
   logic        pc_sel;
   logic        pc_lden;
   logic        rf_wren;
   logic        rf_wrdata_sel;
   logic        rf_b_sel;
   logic        alu_rf_a_sel;
   logic        alu_bin_sel;
   logic [3:0]  alu_func;
   logic        mem_wren;
   logic        illegal;
   logic [3:0]  state_dbg;

   modport master (
      input  Instr, Zero,
      output instr_lden, pc_sel, pc_lden, rf_wren, rf_wrdata_sel, rf_b_sel,
             alu_rf_a_sel, alu_bin_sel, alu_func, mem_wren, illegal, state_dbg
   );

   modport slave (
      output Instr, Zero,
      input  instr_lden, pc_sel, pc_lden, rf_wren, rf_wrdata_sel, rf_b_sel,
             alu_rf_a_sel, alu_bin_sel, alu_func, mem_wren, illegal, state_dbg
   );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing of datapath enables.
// Optional ILLEGAL_TRAP_EN: unknown opcodes lock into a TRAP state (illegal=1) until reset.
module multicycle_control_unit #(
   parameter logic [3:0] ALU_ADD = 4'b0000,
   parameter logic [3:0] ALU_SUB = 4'b0001,
   parameter logic [3:0] ALU_AND = 4'b0010,
   parameter logic [3:0] ALU_OR  = 4'b0011
) (
   input  logic                       Clk,
   input  logic                       Reset,
   multicycle_control_unit_if.master  bus
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      EXEC   = 4'd2,
      WB_ALU = 4'd3,
      MEM_RD = 4'd4,
      WB_MEM = 4'd5,
      MEM_WR = 4'd6,
      BRANCH = 4'd7,
      NOP    = 4'd8
`ifdef ILLEGAL_TRAP_EN
      , TRAP = 4'd9
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b100000;
   localparam logic [5:0] OP_ADDI  = 6'b110000;
   localparam logic [5:0] OP_ANDI  = 6'b110010;
   localparam logic [5:0] OP_ORI   = 6'b110011;
   localparam logic [5:0] OP_LI    = 6'b111000;
   localparam logic [5:0] OP_LUI   = 6'b111001;
   localparam logic [5:0] OP_LW    = 6'b001111;
   localparam logic [5:0] OP_SW    = 6'b011111;
   localparam logic [5:0] OP_B     = 6'b111111;
   localparam logic [5:0] OP_BEQ   = 6'b000000;
   localparam logic [5:0] OP_BNE   = 6'b000001;

   state_t      state_r;
   state_t      state_nxt_s;
   logic [5:0]  op_r;
   logic [3:0]  fn_r;
   logic [5:0]  alu_cfg_s;
   logic        unused_instr_s;

   // ALU setup for an opcode, packed as {a_sel, bin_sel, func}; addi/lw/sw share the default
   function automatic logic [5:0] alu_cfg(input logic [5:0] op, input logic [3:0] fn);
      case (op)
         OP_RTYPE:      alu_cfg = {1'b0, 1'b0, fn};
         OP_ANDI:       alu_cfg = {1'b0, 1'b1, ALU_AND};
         OP_ORI:        alu_cfg = {1'b0, 1'b1, ALU_OR};
         OP_LI, OP_LUI: alu_cfg = {1'b1, 1'b1, ALU_ADD};
         default:       alu_cfg = {1'b0, 1'b1, ALU_ADD};
      endcase
   endfunction

   assign alu_cfg_s      = alu_cfg(op_r, fn_r);
   assign bus.state_dbg  = state_r;
   assign unused_instr_s = ^bus.Instr[25:4];

   // State register plus opcode/function capture on the DECODE edge
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r <= FETCH;
         op_r    <= 6'd0;
         fn_r    <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         if (state_r == DECODE) begin
            op_r <= bus.Instr[31:26];
            fn_r <= bus.Instr[3:0];
         end else begin
            op_r <= op_r;
            fn_r <= fn_r;
         end
      end
   end

   // Next-state decode; DECODE looks at the live opcode because op_r is not yet loaded
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         FETCH:  state_nxt_s = DECODE;
         DECODE: begin
            case (bus.Instr[31:26])
               OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LI, OP_LUI,
               OP_LW, OP_SW:         state_nxt_s = EXEC;
               OP_B, OP_BEQ, OP_BNE: state_nxt_s = BRANCH;
`ifdef ILLEGAL_TRAP_EN
               default:              state_nxt_s = TRAP;
`else
               default:              state_nxt_s = NOP;
`endif
            endcase
         end
         EXEC: begin
            case (op_r)
               OP_LW:   state_nxt_s = MEM_RD;
               OP_SW:   state_nxt_s = MEM_WR;
               default: state_nxt_s = WB_ALU;
            endcase
         end
         MEM_RD:                                state_nxt_s = WB_MEM;
         WB_ALU, WB_MEM, MEM_WR, BRANCH, NOP:   state_nxt_s = FETCH;
`ifdef ILLEGAL_TRAP_EN
         TRAP:                                  state_nxt_s = TRAP;
`endif
         default:                               state_nxt_s = FETCH;
      endcase
   end

   // Moore output decode, forced inactive while reset is held; only BRANCH pc_sel sees Zero
   always_comb begin
      bus.instr_lden    = 1'b0;
      bus.pc_sel        = 1'b0;
      bus.pc_lden       = 1'b0;
      bus.rf_wren       = 1'b0;
      bus.rf_wrdata_sel = 1'b0;
      bus.rf_b_sel      = 1'b0;
      bus.alu_rf_a_sel  = 1'b0;
      bus.alu_bin_sel   = 1'b0;
      bus.alu_func      = ALU_ADD;
      bus.mem_wren      = 1'b0;
      bus.illegal       = 1'b0;
      if (Reset) begin
         case (state_r)
            FETCH:  bus.instr_lden = 1'b1;
            EXEC, MEM_RD: begin
               {bus.alu_rf_a_sel, bus.alu_bin_sel, bus.alu_func} = alu_cfg_s;
            end
            WB_ALU: begin
               {bus.alu_rf_a_sel, bus.alu_bin_sel, bus.alu_func} = alu_cfg_s;
               bus.rf_wren = 1'b1;
               bus.pc_lden = 1'b1;
            end
            WB_MEM: begin
               {bus.alu_rf_a_sel, bus.alu_bin_sel, bus.alu_func} = alu_cfg_s;
               bus.rf_wren       = 1'b1;
               bus.rf_wrdata_sel = 1'b1;
               bus.pc_lden       = 1'b1;
            end
            MEM_WR: begin
               {bus.alu_rf_a_sel, bus.alu_bin_sel, bus.alu_func} = alu_cfg_s;
               bus.rf_b_sel = 1'b1;
               bus.mem_wren = 1'b1;
               bus.pc_lden  = 1'b1;
            end
            BRANCH: begin
               bus.rf_b_sel = 1'b1;
               bus.alu_func = ALU_SUB;
               bus.pc_lden  = 1'b1;
               case (op_r)
                  OP_B:    bus.pc_sel = 1'b1;
                  OP_BEQ:  bus.pc_sel = bus.Zero;
                  OP_BNE:  bus.pc_sel = ~bus.Zero;
                  default: bus.pc_sel = 1'b0;
               endcase
            end
            NOP:    bus.pc_lden = 1'b1;
`ifdef ILLEGAL_TRAP_EN
            TRAP:   bus.illegal = 1'b1;
`endif
            default: bus.instr_lden = 1'b0;
         endcase
      end else begin
         bus.alu_func = ALU_ADD;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench: per-cycle control vectors compared with a table-driven
// model of the instruction classes (latency, ALU config, per-cycle enables).
module tb_multicycle_control_unit;
   logic        Clk = 1'b0;
   logic        Reset;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [13:0] obs;

   localparam logic [5:0] OPS [11] = '{6'b100000, 6'b110000, 6'b110010, 6'b110011, 6'b111000,
                                       6'b111001, 6'b001111, 6'b011111, 6'b111111, 6'b000000,
                                       6'b000001};

   multicycle_control_unit_if bus();
   multicycle_control_unit dut (.Clk(Clk), .Reset(Reset), .bus(bus));

   always #5 Clk = ~Clk;

   assign obs = {bus.instr_lden, bus.pc_sel, bus.pc_lden, bus.rf_wren, bus.rf_wrdata_sel,
                 bus.rf_b_sel, bus.alu_rf_a_sel, bus.alu_bin_sel, bus.alu_func,
                 bus.mem_wren, bus.illegal};

   task automatic check_val(input string tag, input logic [13:0] got, input logic [13:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // 0 alu-writeback, 1 load, 2 store, 3 branch, 4 unknown
   function automatic int op_kind(input logic [5:0] op);
      case (op)
         6'b100000, 6'b110000, 6'b110010, 6'b110011, 6'b111000, 6'b111001: return 0;
         6'b001111: return 1;
         6'b011111: return 2;
         6'b111111, 6'b000000, 6'b000001: return 3;
         default: return 4;
      endcase
   endfunction

   function automatic int model_lat(input logic [5:0] op);
      case (op_kind(op))
         0, 2:    return 4;
         1:       return 5;
`ifdef ILLEGAL_TRAP_EN
         4:       return 22;
`endif
         default: return 3;
      endcase
   endfunction

   function automatic logic [13:0] model(input logic [5:0] op, input logic [3:0] fn,
                                         input logic z, input int k);
      logic il, ps, pl, rw, ws, bs, as, bn, mw, ill;
      logic [3:0] f;
      int kind;
      int lat;
      {il, ps, pl, rw, ws, bs, as, bn, mw, ill} = 10'd0;
      f    = 4'b0000;
      kind = op_kind(op);
      lat  = model_lat(op);
      case (op)
         6'b100000: f = fn;
         6'b110010: begin bn = 1'b1; f = 4'b0010; end
         6'b110011: begin bn = 1'b1; f = 4'b0011; end
         6'b111000, 6'b111001: begin bn = 1'b1; as = 1'b1; end
         6'b110000, 6'b001111, 6'b011111: bn = 1'b1;
         default: bn = 1'b0;
      endcase
      if (k == 1) return 14'b10000000000000;
      if (k == 2) return 14'd0;
      if (kind == 3) begin
         bs = 1'b1; f = 4'b0001; pl = 1'b1;
         ps = (op == 6'b111111) ? 1'b1 : (op == 6'b000000) ? z : ~z;
      end else if (kind == 4) begin
`ifdef ILLEGAL_TRAP_EN
         ill = 1'b1;
`else
         pl = 1'b1;
`endif
      end else if (k == lat) begin
         pl = 1'b1;
         if (kind == 0) rw = 1'b1;
         if (kind == 1) begin rw = 1'b1; ws = 1'b1; end
         if (kind == 2) begin bs = 1'b1; mw = 1'b1; end
      end
      return {il, ps, pl, rw, ws, bs, as, bn, f, mw, ill};
   endfunction

   // zmode: 0/1 hold Zero at that value, 2 randomizes it each cycle; stop_at>0 truncates
   task automatic run_instr(input logic [31:0] ins, input int zmode, input int stop_at);
      int   lat;
      logic z;
      lat = (stop_at > 0) ? stop_at : model_lat(ins[31:26]);
      for (int k = 1; k <= lat; k++) begin
         z = (zmode == 2) ? 1'($urandom_range(1)) : zmode[0];
         bus.Instr = ins;
         bus.Zero  = z;
         #1;
         check_val($sformatf("op%b_c%0d", ins[31:26], k), obs, model(ins[31:26], ins[3:0], z, k));
         @(negedge Clk);
      end
`ifdef ILLEGAL_TRAP_EN
      if (op_kind(ins[31:26]) == 4 && stop_at == 0) begin
         Reset = 1'b0;
         @(negedge Clk);
         Reset = 1'b1;
      end
`endif
   endtask

   initial begin
      logic [5:0] op;
      Reset     = 1'b1;
      bus.Instr = 32'd0;
      bus.Zero  = 1'b0;
      #1 Reset  = 1'b0;
      #1 check_val("reset", obs, 14'd0);
      repeat (2) @(negedge Clk);
      check_val("reset_hold", obs, 14'd0);
      Reset = 1'b1;

      run_instr(32'h80221830, 2, 0);
      run_instr({6'b001111, 26'h0220004}, 2, 0);
      run_instr({6'b011111, 26'h0430008}, 2, 0);
      run_instr({6'b000000, 26'h0220010}, 1, 0);
      run_instr({6'b000000, 26'h0220010}, 0, 0);
      run_instr({6'b000001, 26'h0220010}, 1, 0);
      run_instr({6'b000001, 26'h0220010}, 0, 0);
      run_instr({6'b111111, 26'h0000040}, 0, 0);
      run_instr({6'b111111, 26'h0000040}, 1, 0);
      run_instr({6'b101010, 26'h1234567}, 2, 0);
      run_instr({6'b110010, 26'h0A5000F}, 2, 0);

      // Reset asserted in the writeback cycle of a load
      run_instr({6'b001111, 26'h0220004}, 2, 4);
      #1 check_val("lw_wb_mem", obs, model(6'b001111, 4'd4, bus.Zero, 5));
      Reset = 1'b0;
      #1 check_val("rst_mid_wb", obs, 14'd0);
      @(posedge Clk);
      #1 check_val("rst_mid_hold", obs, 14'd0);
      @(negedge Clk);
      Reset = 1'b1;
      run_instr({6'b111001, 26'h3FFFFFF}, 2, 0);

      for (int i = 0; i < 60; i++) begin
         op = ($urandom_range(3) == 0) ? 6'($urandom) : OPS[$urandom_range(10)];
         run_instr({op, 26'($urandom)}, 2, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
